picorv32_mem_resp: RTL
======================

PICORV32_MEM_RESP -- requirements
Module: picorv32_mem_resp

Interface
REQ-001 Parameter BASE, default 32'h0000_0000, byte address of first RAM word; multiple of 4*WORDS.
REQ-002 Parameter WORDS, default 16384, RAM depth in 32-bit words; power of two.
REQ-003 Parameter WAIT, default 0, extra wait cycles per access, range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cpu_mem_op  input  1  request valid from initiator.
REQ-007 cpu_mem_rdy  output  1  transfer complete strobe to initiator.
REQ-008 cpu_adr  input  32  byte address of request.
REQ-009 cpu_do  input  32  write data from initiator.
REQ-010 cpu_wren  input  4  byte-lane write strobes; 4'b0000 denotes read.
REQ-011 cpu_di  output  32  read data to initiator.
REQ-012 err  output  1  sticky flag, out-of-range access seen.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP; reset state IDLE.
REQ-014 IDLE with cpu_mem_op=0: no change, cpu_mem_rdy=0.
REQ-015 IDLE with cpu_mem_op=1 at edge k: accept; next state RESP if WAIT=0, else WAIT with counter loaded WAIT-1.
REQ-016 WAIT: counter decrements each edge; at 0 move to RESP.
REQ-017 cpu_mem_rdy SHALL be registered, high exactly one cycle while in RESP, then IDLE unconditionally.
REQ-018 Latency: cpu_mem_rdy high in cycle beginning at edge k+1+WAIT.
REQ-019 In range: BASE <= cpu_adr < BASE+4*WORDS; word index = (cpu_adr-BASE)>>2; cpu_adr[1:0] ignored.
REQ-020 In-range write (cpu_wren!=0): lanes with cpu_wren[i]=1 take cpu_do[8i+7:8i] at edge k; other lanes unchanged.
REQ-021 In-range read: synchronous RAM read at edge k; cpu_di holds word at index from cycle k+1 through end of RESP.
REQ-022 In-range write: cpu_di returns pre-write word content (read-before-write) during RESP.
REQ-023 Out-of-range access: no RAM update, cpu_di=32'h0 during RESP, err set at edge k, transfer still completes with normal latency.
REQ-024 cpu_adr, cpu_do, cpu_wren sampled only at edge k; changes during WAIT/RESP ignored.
REQ-025 cpu_mem_op dropping during WAIT/RESP SHALL NOT abort the transfer.
REQ-026 cpu_mem_op=1 in IDLE immediately after RESP accepted as new request (back-to-back, one IDLE cycle between).
REQ-027 cpu_di SHALL hold last value outside RESP; err cleared only by reset.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, cpu_mem_rdy=0, cpu_di=0, err=0, wait counter 0.
REQ-029 Reset mid-transfer SHALL abandon it without a rdy pulse; write committed at acceptance edge persists.
REQ-030 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-031 WAIT=0: write 0xDEADBEEF wren=4'hF to 0x100, then read 0x100 -> rdy one cycle after each accept, read cpu_di=0xDEADBEEF.
REQ-032 Byte lanes: word 0x104=0x11223344, write cpu_do=0xAABBCCDD wren=4'b0101 -> read returns 0x11BB33DD.
REQ-033 WAIT=3: read accepted at edge k -> rdy low edges k+1..k+3, high in cycle after edge k+4, exactly one cycle.
REQ-034 Read 0x0001_0000 (BASE=0, WORDS=16384) -> rdy normal latency, cpu_di=0, err=1 and stays 1 after later valid accesses.
REQ-035 WAIT=5, write 0x55 wren=4'b0001 to 0x200, reset low two cycles after accept -> no rdy, outputs 0, later read of 0x200 byte 0 = 0x55.
REQ-036 Back-to-back reads of 0x0 and 0x4 with cpu_mem_op held high -> two single-cycle rdy pulses, correct data each.

Source files
------------

// File: rtl/picorv32_mem_resp.sv
// Word-organised RAM behind a valid/ready handshake with a fixed number of
// wait states per access and a sticky out-of-range error flag.
module picorv32_mem_resp #(
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int          WORDS = 16384,
   parameter int          WAIT  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_mem_op,
   output logic        cpu_mem_rdy,
   input  logic [31:0] cpu_adr,
   input  logic [31:0] cpu_do,
   input  logic [3:0]  cpu_wren,
   output logic [31:0] cpu_di,
   output logic        err
);

   localparam int         AW        = $clog2(WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rdy_q, rdy_d;
   logic [31:0]   di_q, di_d;
   logic          err_q, err_d;
   logic          accept_s;
   logic          in_range_s;
   logic          wr_en_s;
   logic [AW-1:0] idx_s;
   logic [31:0]   mem_q [WORDS];
   logic          unused_s;

   // BASE is aligned to the RAM size, so range decode is an upper-bit compare.
   assign in_range_s = (cpu_adr[31:AW+2] == BASE[31:AW+2]);
   assign idx_s      = cpu_adr[AW+1:2];
   assign unused_s   = ^cpu_adr[1:0];

   // Handshake sequencing: accept, count wait states, respond.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdy_d    = 1'b0;
      accept_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_mem_op) begin
               accept_s = 1'b1;
               if (WAIT == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            rdy_d   = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Read data and error capture happen only at the acceptance edge.
   always_comb begin
      di_d    = di_q;
      err_d   = err_q;
      wr_en_s = 1'b0;
      if (accept_s) begin
         if (in_range_s) begin
            di_d    = mem_q[idx_s];
            wr_en_s = (cpu_wren != 4'b0000) && reset;
         end else begin
            di_d  = 32'h0000_0000;
            err_d = 1'b1;
         end
      end else begin
         di_d = di_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdy_q   <= 1'b0;
         di_q    <= 32'h0000_0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
         di_q    <= di_d;
         err_q   <= err_d;
      end
   end

   // RAM array keeps its contents through reset; read above sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int i = 0; i < 4; i++) begin
            if (cpu_wren[i]) begin
               mem_q[idx_s][8*i +: 8] <= cpu_do[8*i +: 8];
            end
         end
      end
   end

   assign cpu_mem_rdy = rdy_q;
   assign cpu_di      = di_q;
   assign err         = err_q;

endmodule
